// File: rtl/cg_rr_arbiter.sv
// Grant arbiter with registered outputs: round-robin or fixed priority, with
// an optional lock that re-grants the current winner on handshake.
module cg_rr_arbiter #(
  parameter  int NUM_REQ     = 16,
  parameter  bit RR_MODE     = 1'b1,
  localparam int INDEX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic                   i_lock,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [INDEX_WIDTH-1:0] o_index,
  output logic [NUM_REQ-1:0]     o_onehot
);

  // state | meaning
  // IDLE  | no grant presented, arbitrate every cycle
  // GRANT | grant presented and held until the consumer accepts it
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_REQ - 1);

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic [NUM_REQ-1:0]     onehot_q, onehot_d;
  logic [INDEX_WIDTH-1:0] ptr_arb;
  logic [INDEX_WIDTH-1:0] win_idx;
  logic                   win_found;
  logic                   hs;
  logic                   arb_en;
  logic                   lock_hold;

  assign hs        = (state_q == GRANT) && i_ready;
  assign arb_en    = (state_q == IDLE) || hs;
  assign lock_hold = hs && i_lock && i_req[index_q];

  // The served index drops to lowest priority in the same cycle it is accepted.
  always_comb begin
    ptr_arb = ptr_q;
    if (RR_MODE && hs && !lock_hold) begin
      ptr_arb = (index_q == '0) ? LAST_IDX : index_q - 1'b1;
    end
  end

  always_comb begin
    int cand;
    cand      = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (RR_MODE) begin
        cand = int'(ptr_arb) - i;
        if (cand < 0) cand = cand + NUM_REQ;
      end else begin
        cand = NUM_REQ - 1 - i;
      end
      if (!win_found && i_req[INDEX_WIDTH'(cand)]) begin
        win_idx   = INDEX_WIDTH'(cand);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    onehot_d = onehot_q;
    ptr_d    = ptr_q;
    if (arb_en) begin
      ptr_d = ptr_arb;
      if (lock_hold) begin
        state_d = GRANT;
      end else if (win_found) begin
        state_d           = GRANT;
        index_d           = win_idx;
        onehot_d          = '0;
        onehot_d[win_idx] = 1'b1;
      end else begin
        state_d  = IDLE;
        index_d  = '0;
        onehot_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      index_q  <= '0;
      onehot_q <= '0;
      ptr_q    <= LAST_IDX;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
    end
  end

  assign o_valid  = (state_q == GRANT);
  assign o_index  = index_q;
  assign o_onehot = onehot_q;

endmodule

// File: doc/cg_rr_arbiter.md
CG_RR_ARBITER -- requirements
Module: cg_rr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 16, number of requesters; SHALL be >= 2, need not be a power of two.
REQ-002 Parameter RR_MODE, default 1: 1 = round-robin, 0 = fixed priority (highest index wins).
REQ-003 Localparam INDEX_WIDTH = $clog2(NUM_REQ).
REQ-004 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 i_rst  input  1  reset, synchronous and active-high.
REQ-006 i_req  input  NUM_REQ  request vector; bit k = requester k.
REQ-007 i_lock  input  1  sampled only on handshake; when set, holds the current winner for its next grant.
REQ-008 i_ready  input  1  consumer accepts the presented grant.
REQ-009 o_valid  output  1  grant presented.
REQ-010 o_index  output  INDEX_WIDTH  index of granted requester.
REQ-011 o_onehot  output  NUM_REQ  one-hot of o_index when o_valid=1; all zero otherwise.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 Two states: IDLE (o_valid=0) and GRANT (o_valid=1).
REQ-014 Handshake fires in any cycle where o_valid=1 and i_ready=1.
REQ-015 In GRANT without handshake, o_index and o_onehot SHALL hold stable, whatever i_req and i_lock do, including withdrawal of the granted request.
REQ-016 Arbitration SHALL run in a cycle that is in IDLE or has a handshake. If |i_req=1, the winner SHALL be registered and the block SHALL be in GRANT next cycle. If |i_req=0, the block SHALL be in IDLE next cycle.
REQ-017 Latency: a request arriving in IDLE at cycle N SHALL produce o_valid=1 at cycle N+1.
REQ-018 Back-to-back: a handshake at cycle N with |i_req=1 SHALL present the next grant at N+1, with no bubble.
REQ-019 RR_MODE=0: winner SHALL be the highest set index of i_req; r_ptr is unused.
REQ-020 RR_MODE=1: search SHALL start at r_ptr and descend r_ptr, r_ptr-1, ..., 0, NUM_REQ-1, ... with wrap; the first set bit wins.
REQ-021 RR_MODE=1 pointer update on handshake of index k with i_lock=0: r_ptr SHALL become k-1, or NUM_REQ-1 when k=0.
REQ-022 Arbitration in a handshake cycle SHALL use the updated pointer from REQ-021, so the just-served index has lowest priority.
REQ-023 Lock: on handshake of index k with i_lock=1 and i_req[k]=1, the next grant SHALL be k again and r_ptr SHALL be unchanged. This applies in both modes.
REQ-024 Lock with i_req[k]=0 at handshake SHALL be ignored; REQ-021 applies.
REQ-025 r_ptr SHALL only take values 0..NUM_REQ-1, including when NUM_REQ is not a power of two.
REQ-026 Exactly one o_onehot bit SHALL be set whenever o_valid=1.

Reset
REQ-027 While i_rst=1 at a rising edge: o_valid=0, o_index=0, o_onehot=0, r_ptr=NUM_REQ-1, state IDLE.
REQ-028 Reset SHALL take priority over a simultaneous handshake or request; a grant pending mid-operation SHALL be dropped without being accepted.
REQ-029 The first arbitration after reset SHALL equal the fixed-priority result (highest index).

Verification
REQ-030 NUM_REQ=4, RR: i_req=4'b1111 held, i_ready=1 -> o_index sequence 3,2,1,0,3 on consecutive cycles, o_valid constant 1.
REQ-031 NUM_REQ=4, RR: i_req=4'b0101, i_ready=0 for 3 cycles, then i_req=0 -> o_index=2 held stable; after i_ready=1, o_valid=0 next cycle.
REQ-032 NUM_REQ=5, RR: i_req=5'b10001 held, i_ready=1 -> sequence 4,0,4,0; r_ptr never exceeds 4.
REQ-033 NUM_REQ=4, RR: i_req=4'b1010, i_lock=1 for the first two handshakes, then 0 -> sequence 3,3,3,1,3.
REQ-034 NUM_REQ=4, RR_MODE=0: i_req=4'b0110 held, i_ready=1 -> o_index=2 every cycle; then i_req=4'b0001 -> o_index=0 one cycle later.
REQ-035 Reset during GRANT with i_ready=1 -> next cycle o_valid=0, o_onehot=0; with i_req=4'b0011 afterwards, the first grant is index 1.
